// File: rtl/boc_trk_corr_if.sv
// Bus between the BOC carrier-wipe stage, the E/P/L correlator and the tracking loop filters.
// master drives samples, replicas, strobes and ack; slave (the correlator) returns the dumps.
interface boc_trk_corr_if #(
  parameter int SRC_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int EPC_WIDTH = 16
);
  logic signed [SRC_WIDTH-1:0] rx_src_real;
  logic signed [SRC_WIDTH-1:0] rx_src_imag;
  logic                        rx_loc_bocE;
  logic                        rx_loc_bocP;
  logic                        rx_loc_bocL;
  logic                        rx_prn_sop;
  logic                        rx_trk_rst;
  logic                        rx_corr_ack;
  logic                        tx_corr_vld;
  logic signed [ACC_WIDTH-1:0] tx_IE;
  logic signed [ACC_WIDTH-1:0] tx_QE;
  logic signed [ACC_WIDTH-1:0] tx_IP;
  logic signed [ACC_WIDTH-1:0] tx_QP;
  logic signed [ACC_WIDTH-1:0] tx_IL;
  logic signed [ACC_WIDTH-1:0] tx_QL;
  logic        [EPC_WIDTH-1:0] tx_epoch_cnt;
  logic                        tx_corr_ovf;

  modport master (
    output rx_src_real, rx_src_imag, rx_loc_bocE, rx_loc_bocP, rx_loc_bocL,
           rx_prn_sop, rx_trk_rst, rx_corr_ack,
    input  tx_corr_vld, tx_IE, tx_QE, tx_IP, tx_QP, tx_IL, tx_QL,
           tx_epoch_cnt, tx_corr_ovf
  );

  modport slave (
    input  rx_src_real, rx_src_imag, rx_loc_bocE, rx_loc_bocP, rx_loc_bocL,
           rx_prn_sop, rx_trk_rst, rx_corr_ack,
    output tx_corr_vld, tx_IE, tx_QE, tx_IP, tx_QP, tx_IL, tx_QL,
           tx_epoch_cnt, tx_corr_ovf
  );
endinterface

// File: rtl/boc_trk_corr.sv
// Early/Prompt/Late integrate-and-dump correlator, one dump of six coherent sums per PRN period.
// Optional build macro TRK_CORR_SAT_EN: saturating accumulators instead of two's-complement wrap.
module boc_trk_corr #(
  parameter int SRC_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int EPC_WIDTH = 16
) (
  input  logic           rx_clk,
  input  logic           rx_rst_n,
  boc_trk_corr_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_WAIT  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Accumulator/dump slot order: IE, QE, IP, QP, IL, QL (tap = slot/2, odd slots are Q).
  localparam int NACC = 6;

`ifdef TRK_CORR_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
`ifdef TRK_CORR_SAT_EN
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      if (s[ACC_WIDTH]) begin
        acc_add = ACC_MIN;
      end else begin
        acc_add = ACC_MAX;
      end
    end else begin
      acc_add = s[ACC_WIDTH-1:0];
    end
`else
    acc_add = a + b;
`endif
  endfunction

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q  [NACC];
  logic signed [ACC_WIDTH-1:0] acc_d  [NACC];
  logic signed [ACC_WIDTH-1:0] dump_q [NACC];
  logic signed [ACC_WIDTH-1:0] dump_d [NACC];
  logic                        vld_q, vld_d;
  logic                        ovf_q, ovf_d;
  logic        [EPC_WIDTH-1:0] epc_q, epc_d;

  logic signed [ACC_WIDTH-1:0] src_i_s, src_q_s;
  logic signed [ACC_WIDTH-1:0] contrib_s [NACC];
  logic        [2:0]           boc_s;

  assign boc_s   = {bus.rx_loc_bocL, bus.rx_loc_bocP, bus.rx_loc_bocE};
  assign src_i_s = ACC_WIDTH'(bus.rx_src_real);
  assign src_q_s = ACC_WIDTH'(bus.rx_src_imag);

  // Per-tap signed contribution; negation at full accumulator width keeps -(-2^(SRC_WIDTH-1)) exact.
  always_comb begin
    for (int t = 0; t < 3; t++) begin
      if (boc_s[t]) begin
        contrib_s[2*t]   = src_i_s;
        contrib_s[2*t+1] = src_q_s;
      end else begin
        contrib_s[2*t]   = -src_i_s;
        contrib_s[2*t+1] = -src_q_s;
      end
    end
  end

  // Next-state: tracking restart first, then WAIT/ACCUM sequencing with dump and handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dump_d  = dump_q;
    vld_d   = vld_q & ~bus.rx_corr_ack;
    ovf_d   = ovf_q;
    epc_d   = epc_q;
    if (bus.rx_trk_rst) begin
      state_d = ST_WAIT;
      for (int k = 0; k < NACC; k++) acc_d[k] = {ACC_WIDTH{1'b0}};
      vld_d   = 1'b0;
      ovf_d   = 1'b0;
      epc_d   = {EPC_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (bus.rx_prn_sop) begin
            state_d = ST_ACCUM;
            acc_d   = contrib_s;
          end else begin
            for (int k = 0; k < NACC; k++) acc_d[k] = {ACC_WIDTH{1'b0}};
          end
        end
        ST_ACCUM: begin
          if (bus.rx_prn_sop) begin
            // The sop-cycle sample opens the next period, so the dump excludes it.
            dump_d = acc_q;
            acc_d  = contrib_s;
            vld_d  = 1'b1;
            epc_d  = epc_q + {{(EPC_WIDTH-1){1'b0}}, 1'b1};
            if (vld_q && !bus.rx_corr_ack) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
          end else begin
            for (int k = 0; k < NACC; k++) acc_d[k] = acc_add(acc_q[k], contrib_s[k]);
          end
        end
        default: begin
          state_d = ST_WAIT;
          for (int k = 0; k < NACC; k++) acc_d[k] = {ACC_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, accumulator and dump registers.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q <= ST_WAIT;
      for (int k = 0; k < NACC; k++) begin
        acc_q[k]  <= {ACC_WIDTH{1'b0}};
        dump_q[k] <= {ACC_WIDTH{1'b0}};
      end
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      epc_q <= {EPC_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NACC; k++) begin
        acc_q[k]  <= acc_d[k];
        dump_q[k] <= dump_d[k];
      end
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      epc_q <= epc_d;
    end
  end

  assign bus.tx_corr_vld  = vld_q;
  assign bus.tx_corr_ovf  = ovf_q;
  assign bus.tx_epoch_cnt = epc_q;
  assign bus.tx_IE        = dump_q[0];
  assign bus.tx_QE        = dump_q[1];
  assign bus.tx_IP        = dump_q[2];
  assign bus.tx_QP        = dump_q[3];
  assign bus.tx_IL        = dump_q[4];
  assign bus.tx_QL        = dump_q[5];

endmodule

// File: tb/tb_boc_trk_corr.sv
// Bench for boc_trk_corr: directed scenarios plus randomized traffic against a period-level sum model.
// Built with a 20-bit accumulator so saturation/wrap is reachable in a few dozen cycles.
module tb_boc_trk_corr;
  localparam int SW = 16;
  localparam int AW = 20;
  localparam int EW = 4;
  localparam longint AMAX = (64'sd1 <<< (AW-1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (AW-1));

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  boc_trk_corr_if #(.SRC_WIDTH(SW), .ACC_WIDTH(AW), .EPC_WIDTH(EW)) bus ();

  boc_trk_corr #(.SRC_WIDTH(SW), .ACC_WIDTH(AW), .EPC_WIDTH(EW)) dut (
    .rx_clk   (clk),
    .rx_rst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference: running per-slot sums of the open period and the last delivered dump.
  bit     m_run;
  longint m_acc [6];
  longint m_dump [6];
  bit     m_vld, m_ovf;
  int     m_epc;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint fit(input longint v);
    longint m;
    m = v;
`ifdef TRK_CORR_SAT_EN
    if (v > AMAX) m = AMAX;
    if (v < AMIN) m = AMIN;
`else
    m = v & ((64'sd1 <<< AW) - 64'sd1);
    if (m > AMAX) m = m - (64'sd1 <<< AW);
`endif
    return m;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_vld = 1'b0; m_ovf = 1'b0; m_epc = 0;
    for (int k = 0; k < 6; k++) begin m_acc[k] = 0; m_dump[k] = 0; end
  endtask

  task automatic model_step(input bit sop, input bit trk, input bit ack,
                            input bit [2:0] boc, input int i, input int q);
    longint c [6];
    for (int t = 0; t < 3; t++) begin
      c[2*t]   = boc[t] ? longint'(i) : -longint'(i);
      c[2*t+1] = boc[t] ? longint'(q) : -longint'(q);
    end
    if (trk) begin
      m_run = 1'b0; m_vld = 1'b0; m_ovf = 1'b0; m_epc = 0;
      for (int k = 0; k < 6; k++) m_acc[k] = 0;
    end else if (!m_run) begin
      if (ack) m_vld = 1'b0;
      if (sop) begin
        m_run = 1'b1;
        for (int k = 0; k < 6; k++) m_acc[k] = c[k];
      end
    end else if (sop) begin
      if (m_vld && !ack) m_ovf = 1'b1;
      m_vld = 1'b1;
      m_epc = (m_epc + 1) % (1 << EW);
      for (int k = 0; k < 6; k++) begin m_dump[k] = m_acc[k]; m_acc[k] = c[k]; end
    end else begin
      if (ack) m_vld = 1'b0;
      for (int k = 0; k < 6; k++) m_acc[k] = fit(m_acc[k] + c[k]);
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_vld"}, longint'(bus.tx_corr_vld), longint'(m_vld));
    chk({pfx, "_ovf"}, longint'(bus.tx_corr_ovf), longint'(m_ovf));
    chk({pfx, "_epc"}, longint'(bus.tx_epoch_cnt), longint'(m_epc));
    chk({pfx, "_IE"}, longint'(bus.tx_IE), m_dump[0]);
    chk({pfx, "_QE"}, longint'(bus.tx_QE), m_dump[1]);
    chk({pfx, "_IP"}, longint'(bus.tx_IP), m_dump[2]);
    chk({pfx, "_QP"}, longint'(bus.tx_QP), m_dump[3]);
    chk({pfx, "_IL"}, longint'(bus.tx_IL), m_dump[4]);
    chk({pfx, "_QL"}, longint'(bus.tx_QL), m_dump[5]);
  endtask

  // One clock: drive after the falling edge, model at the rising edge, compare 1 time unit later.
  task automatic cyc(input bit sop, input bit trk, input bit ack,
                     input bit e, input bit p, input bit l, input int i, input int q);
    bus.rx_prn_sop  = sop;
    bus.rx_trk_rst  = trk;
    bus.rx_corr_ack = ack;
    bus.rx_loc_bocE = e;
    bus.rx_loc_bocP = p;
    bus.rx_loc_bocL = l;
    bus.rx_src_real = SW'(i);
    bus.rx_src_imag = SW'(q);
    @(posedge clk);
    model_step(sop, trk, ack, {l, p, e}, i, q);
    #1;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_vld"}, longint'(bus.tx_corr_vld), 0);
    chk({pfx, "_ovf"}, longint'(bus.tx_corr_ovf), 0);
    chk({pfx, "_epc"}, longint'(bus.tx_epoch_cnt), 0);
    chk({pfx, "_IE"}, longint'(bus.tx_IE), 0);
    chk({pfx, "_QE"}, longint'(bus.tx_QE), 0);
    chk({pfx, "_IP"}, longint'(bus.tx_IP), 0);
    chk({pfx, "_QP"}, longint'(bus.tx_QP), 0);
    chk({pfx, "_IL"}, longint'(bus.tx_IL), 0);
    chk({pfx, "_QL"}, longint'(bus.tx_QL), 0);
  endtask

  initial begin
    bit sop_prev;
    bit sop;
    longint exp_sat;
    rst_n = 1'b0;
    bus.rx_prn_sop = 1'b0; bus.rx_trk_rst = 1'b0; bus.rx_corr_ack = 1'b0;
    bus.rx_loc_bocE = 1'b0; bus.rx_loc_bocP = 1'b0; bus.rx_loc_bocL = 1'b0;
    bus.rx_src_real = '0; bus.rx_src_imag = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: constant +100/-50 with all taps +1 over 1000 samples.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100, -50);
    chk("t1_no_first_dump", longint'(bus.tx_corr_vld), 0);
    for (int n = 0; n < 999; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100, -50);
    chk("t1_vld_before_sop", longint'(bus.tx_corr_vld), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100, -50);
    chk("t1_vld", longint'(bus.tx_corr_vld), 1);
    chk("t1_IE", longint'(bus.tx_IE), 100000);
    chk("t1_IP", longint'(bus.tx_IP), 100000);
    chk("t1_IL", longint'(bus.tx_IL), 100000);
    chk("t1_QE", longint'(bus.tx_QE), -50000);
    chk("t1_QP", longint'(bus.tx_QP), -50000);
    chk("t1_QL", longint'(bus.tx_QL), -50000);
    chk("t1_epc", longint'(bus.tx_epoch_cnt), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 100, -50);
    chk("t1_ack_clears", longint'(bus.tx_corr_vld), 0);

    // Scenario 2: prompt alternates, late fixed at -1.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int n = 0; n < 1000; n++)
      cyc(n == 0, 1'b0, 1'b0, 1'b1, (n % 2) == 0, 1'b0, 100, -50);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 100, -50);
    chk("t2_IP", longint'(bus.tx_IP), 0);
    chk("t2_QP", longint'(bus.tx_QP), 0);
    chk("t2_IL", longint'(bus.tx_IL), -100000);
    chk("t2_QL", longint'(bus.tx_QL), 50000);
    chk("t2_IE", longint'(bus.tx_IE), 100000);

    // Scenario 3: two further dumps with no ack overwrite and set sticky overflow.
    for (int n = 0; n < 10; n++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7 * n, -3);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5, 5);
    chk("t3_ovf", longint'(bus.tx_corr_ovf), 1);
    chk("t3_vld", longint'(bus.tx_corr_vld), 1);
    for (int n = 0; n < 5; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -200, 33);
    chk("t3_ovf_sticky", longint'(bus.tx_corr_ovf), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1);
    chk("t3_epc", longint'(bus.tx_epoch_cnt), 3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1);
    chk("t3_rst_ovf", longint'(bus.tx_corr_ovf), 0);
    chk("t3_rst_vld", longint'(bus.tx_corr_vld), 0);
    chk("t3_rst_epc", longint'(bus.tx_epoch_cnt), 0);
    chk("t3_dump_kept", longint'(bus.tx_IE), -1000 + 5);

    // Scenario 4: ack coinciding with a dump, then restart on a sop cycle.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11, 22);
    for (int n = 0; n < 5; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11, 22);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9, 9);
    for (int n = 0; n < 5; n++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 9);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4, 4);
    chk("t4_vld_kept", longint'(bus.tx_corr_vld), 1);
    chk("t4_no_ovf", longint'(bus.tx_corr_ovf), 0);
    chk("t4_new_IE", longint'(bus.tx_IE), 9 - 45);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4, 4);
    for (int n = 0; n < 3; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 4);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8, 8);
    chk("t4_rst_sop_nodump", longint'(bus.tx_corr_vld), 0);
    // Back-to-back sops: a one-sample period.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -32768, 32767);
    chk("t4_b2b_IP", longint'(bus.tx_IP), 8);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    chk("t4_b2b_IP_neg", longint'(bus.tx_IP), 32768);
    chk("t4_b2b_QP", longint'(bus.tx_QP), -32767);

    // Scenario 5: 40 samples of +32767 exceed the 20-bit range.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    for (int n = 0; n < 40; n++) cyc(n == 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32767, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
`ifdef TRK_CORR_SAT_EN
    exp_sat = 524287;
`else
    exp_sat = 40 * 32767 - 1048576;
`endif
    chk("t5_IP_limit", longint'(bus.tx_IP), exp_sat);

    // Scenario 6: asynchronous reset mid-epoch, away from any edge.
    for (int n = 0; n < 7; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 123, 45);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 3);
    chk("t6_no_dump", longint'(bus.tx_corr_vld), 0);

    // Randomized traffic, including epoch-counter wrap and occasional restarts.
    sop_prev = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      sop = ($urandom_range(0, 11) == 0) || (sop_prev && $urandom_range(0, 3) == 0);
      cyc(sop, $urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
          1'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      sop_prev = sop;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
